exec_sequencer: RTL
===================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter: OPCODE_W, 11, opcode field width.
REQ-002 SHALL have parameter: CNT_W, 32, retired-instruction counter width.
REQ-003 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high.
REQ-005 SHALL have port: run  in  1  leave IDLE and begin fetching.
REQ-006 SHALL have port: opcode  in  OPCODE_W  instruction-register opcode, valid from DECODE onward.
REQ-007 SHALL have port: zero  in  1  main-ALU zero flag.
REQ-008 SHALL have port: imem_ready / dmem_ready  in  1 each  memory access complete.
REQ-009 SHALL have ports: imem_req, dmem_read, dmem_write  out  1 each  memory requests.
REQ-010 SHALL have ports: ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src  out  1 each  datapath strobes/selects.
REQ-011 SHALL have ports: alu_op  out  2  ALU-control class; state  out  3  current state; halted  out  1; instr_count  out  CNT_W.

Function
REQ-012 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
REQ-013 SHALL decode: R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000), LDUR 11111000010, STUR 11111000000, CBZ opcode[10:3]=10110100, B opcode[10:5]=000101; any other opcode is illegal.
REQ-014 IDLE: all outputs 0; to FETCH when run=1.
REQ-015 FETCH: imem_req=1 held until imem_ready; in the ready cycle ir_write=1, pc_write=1, pc_src=0, then DECODE; no transition while imem_ready=0.
REQ-016 DECODE: no strobes; illegal opcode -> HALT, else EXECUTE.
REQ-017 EXECUTE: alu_op=10, alu_src=0 for R-type; alu_op=00, alu_src=1 for LDUR/STUR; alu_op=01, alu_src=0 for CBZ; alu_op=00 for B.
REQ-018 EXECUTE exits: R-type -> WRITEBACK; LDUR/STUR -> MEMORY; CBZ -> FETCH with pc_write=zero, pc_src=1; B -> FETCH with pc_write=1, pc_src=1.
REQ-019 MEMORY: alu_op=00, alu_src=1 held; dmem_read (LDUR) or dmem_write (STUR) held until dmem_ready; on ready LDUR -> WRITEBACK, STUR -> FETCH.
REQ-020 WRITEBACK: reg_write=1 for exactly one cycle; mem_to_reg=1 for LDUR, 0 for R-type; then FETCH.
REQ-021 instr_count SHALL increment by 1 on the final cycle of each instruction (WRITEBACK, STUR/CBZ/B exit cycle), wrapping to 0 after all-ones.
REQ-022 HALT: halted=1, all strobes and requests 0, state held until reset; run ignored.
REQ-023 Outputs decode from state, the registered instruction class and the ready/zero inputs only; pc_write/ir_write never assert outside the cycles above.
REQ-024 imem_req and dmem requests SHALL never both be 1 in the same cycle.

Reset
REQ-025 reset=1 at a rising edge SHALL force state=IDLE, halted=0, instr_count=0, all outputs 0 from the next cycle, overriding run and ready inputs.
REQ-026 Reset mid-access SHALL drop any pending imem_req/dmem request immediately; no pc_write/reg_write occurs for the aborted instruction.

Verification
REQ-027 ADD, imem_ready=1 every cycle: states 1,2,3,5,1; reg_write high 1 cycle in WRITEBACK, alu_op=10 in EXECUTE; instr_count 0->1.
REQ-028 LDUR, dmem_ready low 3 cycles: MEMORY lasts 4 cycles with dmem_read=1 throughout; WRITEBACK mem_to_reg=1; total 8 cycles.
REQ-029 CBZ with zero=1 then zero=0: first pc_write=1, pc_src=1 in EXECUTE; second pc_write=0; both return to FETCH, count +2.
REQ-030 Opcode 11111111111: DECODE -> HALT, halted=1, remains with run=1 for 20 cycles; reset -> IDLE, instr_count=0.
REQ-031 Reset during STUR MEMORY with dmem_ready=0: next cycle state=0, dmem_write=0, instr_count unchanged from pre-reset reset value 0.
REQ-032 instr_count preloaded near all-ones via 2^CNT_W-1 retirements (CNT_W=4 build): 16th retire wraps to 0.

Source files
------------

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback for a small
// ARM-style subset, with a retired-instruction counter and a sticky halt on illegal opcodes.
module exec_sequencer #(
  parameter int unsigned OPCODE_W = 11,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic [2:0]          state,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StHalt      = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ClsNone = 3'd0,
    ClsR    = 3'd1,
    ClsLdur = 3'd2,
    ClsStur = 3'd3,
    ClsCbz  = 3'd4,
    ClsB    = 3'd5,
    ClsIll  = 3'd6
  } cls_e;

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [7:0]  OpCbz  = 8'b10110100;
  localparam logic [5:0]  OpB    = 6'b000101;

  state_e           state_q;
  cls_e             cls_q;
  cls_e             dec_cls;
  logic [CNT_W-1:0] instr_count_q;
  logic             retire;
  logic [10:0]      op;

  assign op = opcode[10:0];

  // Opcode is only looked at in DECODE; later states use the registered class.
  always_comb begin
    dec_cls = ClsIll;
    if (op == OpAdd || op == OpSub || op == OpAnd || op == OpOrr) begin
      dec_cls = ClsR;
    end else if (op == OpLdur) begin
      dec_cls = ClsLdur;
    end else if (op == OpStur) begin
      dec_cls = ClsStur;
    end else if (op[10:3] == OpCbz) begin
      dec_cls = ClsCbz;
    end else if (op[10:5] == OpB) begin
      dec_cls = ClsB;
    end
  end

  // Final cycle of every instruction, whichever path it takes.
  always_comb begin
    retire = 1'b0;
    unique case (state_q)
      StExecute:   retire = (cls_q == ClsCbz) || (cls_q == ClsB);
      StMemory:    retire = (cls_q == ClsStur) && dmem_ready;
      StWriteback: retire = 1'b1;
      default:     retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cls_q         <= ClsNone;
      instr_count_q <= '0;
    end else begin
      if (retire) begin
        instr_count_q <= instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      unique case (state_q)
        StIdle: begin
          if (run) state_q <= StFetch;
        end
        StFetch: begin
          if (imem_ready) state_q <= StDecode;
        end
        StDecode: begin
          cls_q   <= dec_cls;
          state_q <= (dec_cls == ClsIll) ? StHalt : StExecute;
        end
        StExecute: begin
          unique case (cls_q)
            ClsR:             state_q <= StWriteback;
            ClsLdur, ClsStur: state_q <= StMemory;
            ClsCbz, ClsB:     state_q <= StFetch;
            default:          state_q <= StHalt;
          endcase
        end
        StMemory: begin
          if (dmem_ready) begin
            state_q <= (cls_q == ClsLdur) ? StWriteback : StFetch;
          end
        end
        StWriteback: state_q <= StFetch;
        StHalt:      state_q <= StHalt;
        default:     state_q <= StIdle;
      endcase
    end
  end

  // Outputs depend only on state, registered class and the ready/zero inputs.
  always_comb begin
    imem_req   = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      StExecute: begin
        unique case (cls_q)
          ClsR: alu_op = 2'b10;
          ClsLdur, ClsStur: alu_src = 1'b1;
          ClsCbz: begin
            alu_op   = 2'b01;
            pc_write = zero;
            pc_src   = 1'b1;
          end
          ClsB: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          default: ;
        endcase
      end
      StMemory: begin
        alu_src    = 1'b1;
        dmem_read  = (cls_q == ClsLdur);
        dmem_write = (cls_q == ClsStur);
      end
      StWriteback: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == ClsLdur);
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign halted      = (state_q == StHalt);
  assign instr_count = instr_count_q;

endmodule
